// File: rtl/ub_pkg.sv
// Helpers shared by the unified-buffer family: counter widths derived from
// extents and the row-major address map y*X_EXT + x.
package ub_pkg;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned ub_addr(input int unsigned y, input int unsigned x,
                                          input int unsigned x_ext);
    return y * x_ext + x;
  endfunction

endpackage

// File: rtl/ub_rep_counter.sv
// Wrap counter 0..MAX with enable and terminal-count flag. Used for every
// write, source and replication coordinate.
module ub_rep_counter #(
  parameter int MAX = 1,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == W'(MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/upsample_ub_stream.sv
// Frame buffer that replays one X_EXT x Y_EXT source frame upsampled by
// SCALE_X x SCALE_Y, letting the next frame be written behind the reader.
module upsample_ub_stream
  import ub_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int X_EXT   = 64,
  parameter int Y_EXT   = 64,
  parameter int SCALE_X = 2,
  parameter int SCALE_Y = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and rd_data/rd_last hold while valid && !ready.

  localparam int XW    = cnt_w(X_EXT);
  localparam int YW    = cnt_w(Y_EXT);
  localparam int RXW   = cnt_w(SCALE_X);
  localparam int RYW   = cnt_w(SCALE_Y);
  localparam int DEPTH = X_EXT * Y_EXT;
  localparam int AW    = cnt_w(DEPTH);

  logic [XW-1:0]     wx, sx;
  logic [YW-1:0]     wy, sy;
  logic [RXW-1:0]    rx;
  logic [RYW-1:0]    ry;
  logic              wx_tc, wy_tc, sx_tc, sy_tc, rx_tc, ry_tc;
  logic              wf, rf;
  logic              wr_fire, issue, read_ok, last_pix;
  logic [AW-1:0]     waddr, raddr;
  logic [DATA_W-1:0] mem [DEPTH];

  // Row-granular hazards: reader trails the writer within a frame; the
  // writer may only run into the next frame on rows the reader has left.
  assign read_ok  = (rf == wf) ? (sy < wy) : 1'b1;
  assign wr_ready = (wf == rf) ? 1'b1 : (wy < sy);
  assign wr_fire  = wr_valid && wr_ready && !flush;
  assign issue    = read_ok && (!rd_valid || rd_ready) && !flush;

  assign waddr = AW'(ub_addr(32'(wy), 32'(wx), X_EXT));
  assign raddr = AW'(ub_addr(32'(sy), 32'(sx), X_EXT));

  assign last_pix = (rx == RXW'(SCALE_X - 1)) && (sx == XW'(X_EXT - 1)) &&
                    (ry == RYW'(SCALE_Y - 1)) && (sy == YW'(Y_EXT - 1));

  ub_rep_counter #(.MAX(X_EXT - 1), .W(XW)) u_wx (
    .clk(clk), .rst(rst_n), .flush(flush), .en(wr_fire), .count(wx), .tc(wx_tc));
  ub_rep_counter #(.MAX(Y_EXT - 1), .W(YW)) u_wy (
    .clk(clk), .rst(rst_n), .flush(flush), .en(wr_fire && wx_tc), .count(wy), .tc(wy_tc));

  // Read iteration order: rx fastest, then sx, ry, sy.
  ub_rep_counter #(.MAX(SCALE_X - 1), .W(RXW)) u_rx (
    .clk(clk), .rst(rst_n), .flush(flush), .en(issue), .count(rx), .tc(rx_tc));
  ub_rep_counter #(.MAX(X_EXT - 1), .W(XW)) u_sx (
    .clk(clk), .rst(rst_n), .flush(flush), .en(issue && rx_tc), .count(sx), .tc(sx_tc));
  ub_rep_counter #(.MAX(SCALE_Y - 1), .W(RYW)) u_ry (
    .clk(clk), .rst(rst_n), .flush(flush), .en(issue && rx_tc && sx_tc),
    .count(ry), .tc(ry_tc));
  ub_rep_counter #(.MAX(Y_EXT - 1), .W(YW)) u_sy (
    .clk(clk), .rst(rst_n), .flush(flush), .en(issue && rx_tc && sx_tc && ry_tc),
    .count(sy), .tc(sy_tc));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wf <= 1'b0;
      rf <= 1'b0;
    end else if (flush) begin
      wf <= 1'b0;
      rf <= 1'b0;
    end else begin
      if (wr_fire && wx_tc && wy_tc) wf <= ~wf;
      if (issue && rx_tc && sx_tc && ry_tc && sy_tc) rf <= ~rf;
    end
  end

  // Storage is deliberately never cleared; hazards keep stale words unread.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[waddr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
    end else if (flush) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
    end else if (issue) begin
      rd_valid <= 1'b1;
      rd_data  <= mem[raddr];
      rd_last  <= last_pix;
    end else if (rd_valid && rd_ready) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_upsample_ub_stream.sv
// Bench for upsample_ub_stream: random frames are replayed through a
// queue-based nearest-neighbour model and compared output by output.
module tb_upsample_ub_stream;

  localparam int DW   = 16;
  localparam int X    = 4;
  localparam int Y    = 3;
  localparam int SX   = 2;
  localparam int SY   = 2;
  localparam int NPIX = X * Y;
  localparam int NOUT = NPIX * SX * SY;

  typedef logic [DW-1:0] frame_t [NPIX];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          flush, wr_valid, wr_ready, rd_valid, rd_ready, rd_last;
  logic [DW-1:0] wr_data, rd_data;
  logic          flush2, wr_valid2, wr_ready2, rd_valid2, rd_ready2, rd_last2;
  logic [DW-1:0] wr_data2, rd_data2;

  upsample_ub_stream #(.DATA_W(DW), .X_EXT(X), .Y_EXT(Y), .SCALE_X(SX), .SCALE_Y(SY)) dut (
    .clk(clk), .rst_n(rst), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last));

  upsample_ub_stream #(.DATA_W(DW), .X_EXT(2), .Y_EXT(2), .SCALE_X(3), .SCALE_Y(1)) dut2 (
    .clk(clk), .rst_n(rst), .flush(flush2),
    .wr_valid(wr_valid2), .wr_ready(wr_ready2), .wr_data(wr_data2),
    .rd_valid(rd_valid2), .rd_ready(rd_ready2), .rd_data(rd_data2), .rd_last(rd_last2));

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- scoreboard ----------------
  logic [DW:0]   exp_q[$];   // {last, data}
  logic [DW-1:0] wr_q[$];

  task automatic model_frame(input frame_t f);
    logic lst;
    for (int oy = 0; oy < Y * SY; oy++) begin
      for (int ox = 0; ox < X * SX; ox++) begin
        lst = (oy == Y * SY - 1) && (ox == X * SX - 1);
        exp_q.push_back({lst, f[(oy / SY) * X + ox / SX]});
      end
    end
    for (int i = 0; i < NPIX; i++) wr_q.push_back(f[i]);
  endtask

  task automatic rand_frame(output frame_t f);
    for (int i = 0; i < NPIX; i++) f[i] = DW'($urandom_range(16'hffff));
  endtask

  // ---------------- drivers ----------------
  task automatic drive_writes(input int gap_pct, output int blocked);
    int guard;
    guard   = 0;
    blocked = 0;
    while (wr_q.size() > 0) begin
      @(negedge clk);
      guard++;
      if (guard > 5000) begin
        n_total++;
        $display("FAIL write_timeout: %0d pixels left, required 0", wr_q.size());
        break;
      end
      if ($urandom_range(99) < gap_pct) begin
        wr_valid = 1'b0;
        continue;
      end
      wr_valid = 1'b1;
      wr_data  = wr_q[0];
      if (wr_ready) void'(wr_q.pop_front());
      else blocked++;
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: toggle each cycle, 2: random
  task automatic consume(input int n, input int mode, output int bubbles);
    int          got, guard;
    logic        held_v, held_l, started;
    logic [DW-1:0] held_d;
    logic [DW:0] e;
    got = 0; guard = 0; held_v = 0; held_l = 0; held_d = '0; started = 0;
    bubbles = 0;
    while (got < n) begin
      @(negedge clk);
      guard++;
      if (guard > 5000) begin
        n_total++;
        $display("FAIL read_timeout: got %0d outputs, required %0d", got, n);
        break;
      end
      if (held_v) begin
        n_total++;
        if (rd_valid !== 1'b1 || rd_data !== held_d || rd_last !== held_l)
          $display("FAIL stall_hold: valid=%b data=%h last=%b, required 1 %h %b",
                   rd_valid, rd_data, rd_last, held_d, held_l);
        else n_pass++;
      end
      if (started && !rd_valid) bubbles++;
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (guard % 2 == 1);
        default: rd_ready = 1'($urandom_range(1));
      endcase
      held_v = rd_valid && !rd_ready;
      held_d = rd_data;
      held_l = rd_last;
      if (rd_valid && rd_ready) begin
        started = 1;
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_output: data=%h, required no output", rd_data);
        end else begin
          e = exp_q.pop_front();
          if (rd_data !== e[DW-1:0] || rd_last !== e[DW])
            $display("FAIL output_%0d: data=%h last=%b, required %h %b",
                     got, rd_data, rd_last, e[DW-1:0], e[DW]);
          else n_pass++;
        end
        got++;
      end
    end
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; flush = 0; wr_valid = 0; wr_data = '0; rd_ready = 0;
    flush2 = 0; wr_valid2 = 0; wr_data2 = '0; rd_ready2 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (rd_valid !== 1'b0 || rd_data !== '0 || rd_last !== 1'b0)
      $display("FAIL reset_outputs: valid=%b data=%h last=%b, required 0 0000 0",
               rd_valid, rd_data, rd_last);
    else n_pass++;
    n_total++;
    if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready: %b, required 1", wr_ready);
    else n_pass++;
    n_total++;
    if (rd_valid2 !== 1'b0 || wr_ready2 !== 1'b1)
      $display("FAIL reset_dut2: rd_valid=%b wr_ready=%b, required 0 1", rd_valid2, wr_ready2);
    else n_pass++;
  endtask

  task automatic test_basic_frame;
    frame_t f;
    int     blocked, bubbles;
    for (int i = 0; i < NPIX; i++) f[i] = DW'(i);
    model_frame(f);
    // partial first row must not release any output
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = wr_q.pop_front();
    end
    @(negedge clk);
    wr_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_total++;
      if (rd_valid !== 1'b0) $display("FAIL partial_row_idle: rd_valid=%b, required 0", rd_valid);
      else n_pass++;
    end
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = wr_q.pop_front();
    n_total++;
    if (wr_ready !== 1'b1) $display("FAIL row0_wr_ready: %b, required 1", wr_ready);
    else n_pass++;
    @(negedge clk);
    wr_valid = 1'b0;
    n_total++;
    if (rd_valid !== 1'b0) $display("FAIL latency_early: rd_valid=%b, required 0", rd_valid);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (rd_valid !== 1'b1) $display("FAIL latency_first: rd_valid=%b, required 1", rd_valid);
    else n_pass++;
    fork
      drive_writes(0, blocked);
      consume(NOUT, 0, bubbles);
    join
    repeat (3) @(negedge clk);
    n_total++;
    if (rd_valid !== 1'b0 || exp_q.size() != 0)
      $display("FAIL frame_drained: rd_valid=%b pending=%0d, required 0 0", rd_valid, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    frame_t a, b;
    int     blocked, bubbles;
    rand_frame(a);
    for (int i = 0; i < NPIX; i++) b[i] = DW'(100 + i);
    model_frame(a);
    model_frame(b);
    fork
      drive_writes(0, blocked);
      consume(2 * NOUT, 0, bubbles);
    join
    n_total++;
    if ((blocked > 0) !== 1'b1)
      $display("FAIL b2b_writer_blocked: blocked cycles %0d, required >0", blocked);
    else n_pass++;
    n_total++;
    if (bubbles !== 0) $display("FAIL b2b_no_gap: bubbles %0d, required 0", bubbles);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (rd_valid !== 1'b0 || exp_q.size() != 0)
      $display("FAIL b2b_drained: rd_valid=%b pending=%0d, required 0 0", rd_valid, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_stall;
    frame_t f;
    int     blocked, bubbles;
    rand_frame(f);
    model_frame(f);
    fork
      drive_writes(30, blocked);
      consume(NOUT, 1, bubbles);
    join
    rand_frame(f);
    model_frame(f);
    fork
      drive_writes(50, blocked);
      consume(NOUT, 2, bubbles);
    join
    n_total++;
    if (exp_q.size() != 0) $display("FAIL stall_drained: pending=%0d, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_flush;
    frame_t f;
    int     blocked, bubbles;
    rand_frame(f);
    model_frame(f);
    fork
      drive_writes(0, blocked);
      consume(10, 0, bubbles);
    join
    @(negedge clk);
    flush    = 1'b1;
    rd_ready = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 16'hdead;
    @(negedge clk);
    flush    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    n_total++;
    if (rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== '0)
      $display("FAIL flush_outputs: valid=%b last=%b data=%h, required 0 0 0000",
               rd_valid, rd_last, rd_data);
    else n_pass++;
    n_total++;
    if (wr_ready !== 1'b1) $display("FAIL flush_wr_ready: %b, required 1", wr_ready);
    else n_pass++;
    exp_q.delete();
    wr_q.delete();
    for (int i = 0; i < NPIX; i++) f[i] = DW'(20 + i);
    model_frame(f);
    fork
      drive_writes(20, blocked);
      consume(NOUT, 2, bubbles);
    join
    repeat (3) @(negedge clk);
    n_total++;
    if (rd_valid !== 1'b0 || exp_q.size() != 0)
      $display("FAIL flush_refill_drained: rd_valid=%b pending=%0d, required 0 0",
               rd_valid, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_scale3;
    logic [DW-1:0] d [4];
    logic [DW:0]   e;
    int            got, guard;
    d[0] = 16'd5; d[1] = 16'd6; d[2] = 16'd7; d[3] = 16'd8;
    for (int o = 0; o < 12; o++) begin
      e = {(o == 11), d[(o / 6) * 2 + (o % 6) / 3]};
      exp_q.push_back(e);
    end
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          wr_valid2 = 1'b1;
          wr_data2  = d[i];
          n_total++;
          if (wr_ready2 !== 1'b1) $display("FAIL s3_wr_ready_%0d: %b, required 1", i, wr_ready2);
          else n_pass++;
        end
        @(negedge clk);
        wr_valid2 = 1'b0;
      end
      begin
        got = 0; guard = 0;
        while (got < 12) begin
          @(negedge clk);
          guard++;
          if (guard > 500) begin
            n_total++;
            $display("FAIL s3_timeout: got %0d, required 12", got);
            break;
          end
          rd_ready2 = 1'b1;
          if (rd_valid2) begin
            e = exp_q.pop_front();
            n_total++;
            if (rd_data2 !== e[DW-1:0] || rd_last2 !== e[DW])
              $display("FAIL s3_output_%0d: data=%0d last=%b, required %0d %b",
                       got, rd_data2, rd_last2, e[DW-1:0], e[DW]);
            else n_pass++;
            got++;
          end
        end
        @(negedge clk);
        rd_ready2 = 1'b0;
      end
    join
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_stall();
    test_flush();
    test_scale3();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/upsample_ub_stream.md
# upsample_ub_stream

Parametrised, stream-interfaced successor to the per-op unified buffers: stores one X_EXT×Y_EXT source frame and emits it upsampled by integer factors SCALE_X×SCALE_Y (nearest-neighbour replication). Address generation, row-granular write/read hazard tracking and overlapped next-frame writing are internal. The block sits between the input-stencil producer and the upsampled-stencil consumer.

## Interface
Parameters:
- DATA_W, 16, pixel width
- X_EXT, 64, source columns
- Y_EXT, 64, source rows
- SCALE_X, 2, horizontal replication, ≥1
- SCALE_Y, 2, vertical replication, ≥1

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous clear of all control state
- wr_valid  in  1  write pixel offered
- wr_ready  out  1  write pixel accepted when wr_valid&&wr_ready
- wr_data  in  DATA_W  source pixel, row-major order
- rd_valid  out  1  output pixel present
- rd_ready  in  1  consumer accepts when rd_valid&&rd_ready
- rd_data  out  DATA_W  upsampled pixel, row-major order
- rd_last  out  1  qualifies the final pixel of an output frame

## Operation
- Storage: RAM of X_EXT*Y_EXT words; address = y*X_EXT + x. Contents are never cleared.
- Write side: counters wx (0..X_EXT-1) and wy (0..Y_EXT-1), plus a frame bit wf.
  - Each accepted write stores at (wy,wx) and advances wx. Wrap of wx advances wy.
  - Wrap of wy toggles wf.
- Read side: source counters sx, sy, replicate counters rx (0..SCALE_X-1), ry (0..SCALE_Y-1), and frame bit rf.
  - Iteration order per issued read: rx, then sx, then ry, then sy; frame end toggles rf.
  - Source address = sy*X_EXT + sx. There is no divider; replication is by counters only.
- Hazards use row granularity on registered state only:
  - read_ok = (rf==wf) ? (sy < wy) : 1.
  - wr_ready = (wf==rf) ? 1 : (wy < sy).
  - This lets the writer fill the next frame behind the reader and never exceed one frame ahead.
- Read issue: when read_ok && (!rd_valid || rd_ready). A read registers RAM data into rd_data, sets rd_valid and advances the read counters.
  - rd_last = 1 for the issue with sx=X_EXT-1, rx=SCALE_X-1, sy=Y_EXT-1, ry=SCALE_Y-1.
- An output handshake with no new issue clears rd_valid.
- flush and rst_n both zero all counters, wf, rf, rd_valid, rd_data and rd_last. flush has priority over any handshake in the same cycle.

## Timing
- Reset values: rd_valid=0, rd_data=0, rd_last=0, wr_ready=1 (wf==rf).
- Write-to-read latency: the accept of the last pixel of source row 0 at edge t makes read_ok true after t. The first rd_valid is visible after edge t+1.
- Read throughput: 1 pixel/cycle while read_ok and the consumer is ready. rd_data/rd_last are held stable while rd_valid && !rd_ready.
- Same-cycle write-row completion and read-row completion: each side sees the other's pre-edge values. The result is conservative with no bypass.
- Steady state: a writer blocked on the next frame resumes the cycle after sy increments past wy.
- Reset mid-frame: all in-flight output is discarded. The next frame restarts at (0,0) with both frame bits 0.
- SCALE_X=SCALE_Y=1 degenerates to a row-hazarded FIFO-of-frames.

## Structure
- Shared package ub_pkg holds:
  - clog2-derived width helpers (counter widths for X_EXT, Y_EXT, SCALE_*)
  - the address-computation function y*X_EXT+x, common to all unified buffers
- One sub-module, ub_rep_counter: a wrap counter with enable, max-value parameter and terminal-count output, synchronous flush and async reset. It is instantiated for wx, wy, sx, sy, rx and ry.
- Top holds the RAM, frame bits, hazard compare, issue logic and output register.

## Test plan
Use X_EXT=4, Y_EXT=3, SCALE_X=SCALE_Y=2 unless noted.
- Reset, then idle: rd_valid=0, wr_ready=1, rd_data=0; no read issues until 4 writes are accepted.
- Write 0..11 with rd_ready=1 throughout -> 48 outputs in order 0,0,1,1,2,2,3,3 (twice), 4,4,…,7,7 (twice), 8,8,…,11,11 (twice), with rd_last only on output 48.
- Continuous write of frame 2 (100..111) immediately after frame 1, with rd_ready=1 -> wr_ready drops at wy=sy. Frame 1 output is uncorrupted, and frame 2 output follows with no gap after its row 0 is written.
- rd_ready toggled 1/0 each cycle -> rd_data held during stalls; the sequence is identical to the unstalled run.
- Assert flush mid-frame at output 10 -> rd_valid=0 the next cycle and wr_ready=1. A new frame 20..31 produces 20,20,21,… with no residue.
- SCALE_X=3, SCALE_Y=1, X_EXT=2, Y_EXT=2, data 5,6,7,8 -> outputs 5,5,5,6,6,6,7,7,7,8,8,8.
